hdmi_video_sequencer: RTL and testbench
=======================================

# hdmi_video_sequencer

Controller between the pixel sources and the HDMI encoder. Holds video muted until the pixel PLL is locked and a configurable number of frames have passed. It then selects one of four 24-bit RGB sources and forwards it with aligned syncs. Source changes from the debounced user key (KEY0) only take effect at frame boundaries, and each change is followed by one black frame so the sink never shows a torn picture.

## Interface
Parameters:
- MUTE_FRAMES, 2: black frames after lock before video is enabled (1..15).
- DEBOUNCE_CYCLES, 250000: stable pixel_clock cycles required to accept a key level (≥2, counter width $clog2).
- AUTO_FRAMES, 600: frames per source in auto-cycle mode (used only with HDMI_SEQ_AUTOCYCLE_EN).

Ports (one clock; reset is asynchronous and active-high):
- pixel_clock  in  1  pixel clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pll_lock  in  1  PLL lock, asynchronous; 2-flop synchronized internally
- key_n  in  1  user button, active-low, asynchronous; 2-flop synchronized
- hsync_in, vsync_in, active_in  in  1 each  timing from hvsync, active-high
- src0_rgb, src1_rgb, src2_rgb, src3_rgb  in  24 each  {R,G,B} pixel sources
- rgb_out  out  24  pixel to HDMI encoder
- hsync_out, vsync_out, active_out  out  1 each  timing delayed to match rgb_out
- src_sel  out  2  currently displayed source index
- video_en  out  1  high only in RUN

## Operation
- Frame edge (fe): single-cycle pulse on vsync_in 0→1 (previous-sample register).
- Debounce: a counter clears whenever the synchronized key level differs from the debounced level. When the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value. A press is a debounced 1→0 transition (one-cycle pulse).
- FSM states:
  - WAIT_LOCK: when lock_sync=1, frame counter←0, go to MUTE.
  - MUTE: each fe increments the frame counter. At fe with count=MUTE_FRAMES-1, go to RUN.
  - RUN: a press sets pending. At fe with pending=1: pending←0, src_sel←src_sel+1 (3 wraps to 0), go to SWITCH.
  - SWITCH: at the next fe, go to RUN.
- In any state, lock_sync=0 forces WAIT_LOCK on the next edge and clears pending. src_sel is retained.
- Press and fe in the same cycle: pending is set, and the switch happens at the following fe.
- Presses in WAIT_LOCK, MUTE or SWITCH, or while pending=1, are discarded.
- Pixel path:
  - rgb_out = selected source when state=RUN and active_in=1, else 24'h000000.
  - hsync/vsync/active always pass through, in every state.

## Timing
- Reset values: rgb_out=0, hsync_out=0, vsync_out=0, active_out=0, src_sel=0, video_en=0, state=WAIT_LOCK, pending=0, all counters 0.
- Latency is one pixel_clock from the *_in/srcN_rgb inputs to all outputs. Syncs and pixel are registered in the same stage, so alignment is exact.
- The state change at an fe edge governs the pixel registered on the next edge. The first pixel of the new frame therefore already uses the new state or src_sel.
- lock 1→0 to black output: 2 sync stages + 1 state edge + 1 output register = 4 cycles.
- video_en is registered and mirrors state==RUN with the same one-cycle relation.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously).

## Configuration
- HDMI_SEQ_AUTOCYCLE_EN defined: a frame counter in RUN counts fe events. When it reaches AUTO_FRAMES-1 with no pending press, it advances src_sel exactly like a press (through SWITCH) and clears itself. A key press also clears it. The counter resets on entering RUN.
- HDMI_SEQ_AUTOCYCLE_EN undefined: there is no counter logic, and sources change only by key.

## Test plan
(Bench parameters: MUTE_FRAMES=2, DEBOUNCE_CYCLES=8, AUTO_FRAMES=3, short frames.)
- Reset, then assert pll_lock → rgb_out=0 during WAIT_LOCK and the first 2 frames; video_en=1 and rgb_out=src0_rgb for active pixels starting with the 3rd frame.
- In RUN, hold key_n=0 for 20 cycles mid-frame → next frame all-black, src_sel=1; the frame after shows src1_rgb. Hold src_sel=3, press → src_sel=0.
- key_n glitches of 5 cycles low (below DEBOUNCE_CYCLES) → no change in src_sel. Two valid presses within one frame → only one advance.
- Drop pll_lock mid-frame in RUN → rgb_out=0 and video_en=0 within 4 cycles; syncs keep toggling. Relock → 2 black frames, then the same src_sel resumes.
- Press whose qualified pulse coincides with the fe cycle → switch occurs at the following fe, not the current one.
- With HDMI_SEQ_AUTOCYCLE_EN, no key → src_sel advances 0→1 after 3 RUN frames, with 1 black frame inserted. Without the macro, src_sel stays 0 over 20 frames.

Source files
------------

// File: rtl/hdmi_video_sequencer_if.sv
// hdmi_video_sequencer_if: pixel sources, timing and control into the sequencer, encoder-side pixel/timing out
// master drives pll_lock, key_n, hsync_in, vsync_in, active_in and src0..3_rgb;
// slave (the sequencer) drives rgb_out, hsync_out, vsync_out, active_out, src_sel and video_en.
interface hdmi_video_sequencer_if;
  logic pll_lock, key_n, hsync_in, vsync_in, active_in;
  logic [23:0] src0_rgb, src1_rgb, src2_rgb, src3_rgb;
  logic [23:0] rgb_out;
  logic hsync_out, vsync_out, active_out, video_en;
  logic [1:0] src_sel;
  modport master(
    output pll_lock, key_n, hsync_in, vsync_in, active_in, src0_rgb, src1_rgb, src2_rgb, src3_rgb,
    input rgb_out, hsync_out, vsync_out, active_out, src_sel, video_en
  );
  modport slave(
    input pll_lock, key_n, hsync_in, vsync_in, active_in, src0_rgb, src1_rgb, src2_rgb, src3_rgb,
    output rgb_out, hsync_out, vsync_out, active_out, src_sel, video_en
  );
endinterface

// File: rtl/hdmi_video_sequencer.sv
// hdmi_video_sequencer: mutes video until PLL lock + MUTE_FRAMES, forwards one of four RGB sources with aligned syncs
// Ports: pixel_clock (all logic on rising edge), reset (async, active-high),
//   vid (slave modport): pll_lock/key_n async inputs, hsync/vsync/active_in timing, src0..3_rgb pixels in;
//   rgb_out, hsync/vsync/active_out (one-cycle latency), src_sel, video_en out.
// Optional build macro HDMI_SEQ_AUTOCYCLE_EN: advance the source automatically every AUTO_FRAMES frames in RUN.
module hdmi_video_sequencer #(
  parameter int MUTE_FRAMES = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES = 600
) (
  input logic pixel_clock,
  input logic reset,
  hdmi_video_sequencer_if.slave vid
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {WAIT_LOCK, MUTE, RUN, SWITCH} state_t;
  state_t state;
  logic lock_meta, lock_sync, key_meta, key_sync, key_deb, key_deb_d, vs_prev, pending;
  logic [DW-1:0] deb_cnt;
  logic [3:0] frame_cnt;
  logic [1:0] sel;
  logic fe, press;
  logic [23:0] src_pix;
  assign fe = vid.vsync_in & ~vs_prev;
  assign press = key_deb_d & ~key_deb;
  assign src_pix = sel[1] ? (sel[0] ? vid.src3_rgb : vid.src2_rgb) : (sel[0] ? vid.src1_rgb : vid.src0_rgb);
  assign vid.src_sel = sel;
`ifdef HDMI_SEQ_AUTOCYCLE_EN
  localparam int AW = $clog2(AUTO_FRAMES + 1);
  logic [AW-1:0] auto_cnt;
  logic auto_hit;
  // a press in the same cycle wins: it clears the counter and queues its own switch
  assign auto_hit = fe & ~pending & ~press & (auto_cnt == AW'(AUTO_FRAMES - 1));
`endif
  // key levels reset to the released (high) level so leaving reset never looks like a press
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      key_deb <= 1'b1;
      key_deb_d <= 1'b1;
      deb_cnt <= '0;
      vs_prev <= 1'b0;
    end else begin
      lock_meta <= vid.pll_lock;
      lock_sync <= lock_meta;
      key_meta <= vid.key_n;
      key_sync <= key_meta;
      key_deb_d <= key_deb;
      vs_prev <= vid.vsync_in;
      // count only while the key disagrees with the accepted level; any bounce back restarts it
      if (key_sync == key_deb) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        key_deb <= key_sync;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      state <= WAIT_LOCK;
      pending <= 1'b0;
      sel <= 2'd0;
      frame_cnt <= '0;
`ifdef HDMI_SEQ_AUTOCYCLE_EN
      auto_cnt <= '0;
`endif
    end else if (!lock_sync) begin
      state <= WAIT_LOCK;
      pending <= 1'b0;
    end else begin
`ifdef HDMI_SEQ_AUTOCYCLE_EN
      // held at zero outside RUN so every entry into RUN starts a fresh count
      if (state != RUN) auto_cnt <= '0;
`endif
      case (state)
        WAIT_LOCK: begin
          frame_cnt <= '0;
          state <= MUTE;
        end
        MUTE: if (fe) begin
          frame_cnt <= frame_cnt + 1'b1;
          if (frame_cnt == 4'(MUTE_FRAMES - 1)) state <= RUN;
        end
        RUN: if (fe && pending) begin
          pending <= 1'b0;
          sel <= sel + 1'b1;
          state <= SWITCH;
        end
`ifdef HDMI_SEQ_AUTOCYCLE_EN
        else if (auto_hit) begin
          sel <= sel + 1'b1;
          state <= SWITCH;
        end else begin
          if (press) pending <= 1'b1;
          if (press) auto_cnt <= '0;
          else if (fe) auto_cnt <= auto_cnt + 1'b1;
        end
`else
        else if (press) pending <= 1'b1;
`endif
        default: if (fe) state <= RUN;
      endcase
    end
  // pixel and syncs share one register stage, so they stay exactly aligned
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      vid.rgb_out <= '0;
      vid.hsync_out <= 1'b0;
      vid.vsync_out <= 1'b0;
      vid.active_out <= 1'b0;
      vid.video_en <= 1'b0;
    end else begin
      vid.rgb_out <= (state == RUN && vid.active_in) ? src_pix : 24'h000000;
      vid.hsync_out <= vid.hsync_in;
      vid.vsync_out <= vid.vsync_in;
      vid.active_out <= vid.active_in;
      vid.video_en <= state == RUN;
    end
endmodule

// File: tb/tb_hdmi_video_sequencer.sv
// tb_hdmi_video_sequencer: directed frame-level checks of muting, key switching, lock loss and reset
module tb_hdmi_video_sequencer;
  localparam int FL = 64;
  localparam logic [23:0] S0 = 24'h100001;
  localparam logic [23:0] S1 = 24'h200002;
  localparam logic [23:0] S2 = 24'h300003;
  localparam logic [23:0] S3 = 24'h400004;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int p = 0;
  logic a_d, h_d, v_d;
  logic [23:0] srcs [4];
  hdmi_video_sequencer_if vid();
  hdmi_video_sequencer #(.MUTE_FRAMES(2), .DEBOUNCE_CYCLES(8), .AUTO_FRAMES(3)) dut (
    .pixel_clock(clk),
    .reset(rst),
    .vid(vid)
  );
  always #5 clk = ~clk;
  // 64-cycle frame: vsync on positions 0..3, 16-cycle lines, 3 lines of 12 active pixels
  task automatic drive_timing();
    vid.hsync_in = (p % 16) < 2;
    vid.vsync_in = p < 4;
    vid.active_in = (p >= 16) && ((p % 16) >= 4);
  endtask
  task automatic step();
    a_d = vid.active_in;
    h_d = vid.hsync_in;
    v_d = vid.vsync_in;
    @(posedge clk);
    #1;
    p = (p + 1) % FL;
    drive_timing();
  endtask
  task automatic align();
    while (p != 0) step();
  endtask
  task automatic run_cycles(input int n, input logic [23:0] exp, output int n_bad, output int n_sbad);
    n_bad = 0;
    n_sbad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (vid.rgb_out !== (a_d ? exp : 24'h0)) n_bad++;
      if ({vid.hsync_out, vid.vsync_out, vid.active_out} !== {h_d, v_d, a_d}) n_sbad++;
    end
  endtask
  task automatic press(input int n);
    vid.key_n = 1'b0;
    repeat (n) step();
    vid.key_n = 1'b1;
    repeat (n) step();
  endtask
  task automatic test_reset();
    int bad, sbad;
    rst = 1'b1;
    repeat (3) step();
    compared++;
    if ({vid.rgb_out, vid.hsync_out, vid.vsync_out, vid.active_out, vid.src_sel, vid.video_en} !== 30'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want 0", {vid.rgb_out, vid.hsync_out, vid.vsync_out, vid.active_out, vid.src_sel, vid.video_en});
    end
    rst = 1'b0;
    align();
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL wait_lock_black: %0d bad pixels, want 0", bad); end
    compared++;
    if (sbad !== 0) begin mismatched++; $display("FAIL wait_lock_syncs: %0d bad sync samples, want 0", sbad); end
    compared++;
    if (vid.video_en !== 1'b0) begin mismatched++; $display("FAIL wait_lock_en: got %b want 0", vid.video_en); end
  endtask
  task automatic test_lock_mute();
    int bad, sbad;
    repeat (10) step();
    vid.pll_lock = 1'b1;
    run_cycles(FL - 10, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL mute_partial_black: %0d bad pixels, want 0", bad); end
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL mute_frame_black: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.video_en !== 1'b0) begin mismatched++; $display("FAIL mute_en: got %b want 0", vid.video_en); end
    run_cycles(FL, S0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL run_first_frame: %0d bad pixels, want 0", bad); end
    compared++;
    if (sbad !== 0) begin mismatched++; $display("FAIL run_syncs: %0d bad sync samples, want 0", sbad); end
    compared++;
    if (vid.video_en !== 1'b1) begin mismatched++; $display("FAIL run_en: got %b want 1", vid.video_en); end
    compared++;
    if (vid.src_sel !== 2'd0) begin mismatched++; $display("FAIL run_sel: got %0d want 0", vid.src_sel); end
  endtask
  task automatic test_no_autocycle();
    int bad, sbad, tot;
    tot = 0;
    repeat (20) begin
      run_cycles(FL, S0, bad, sbad);
      tot += bad;
    end
    compared++;
    if (tot !== 0) begin mismatched++; $display("FAIL no_auto_pixels: %0d bad pixels, want 0", tot); end
    compared++;
    if (vid.src_sel !== 2'd0) begin mismatched++; $display("FAIL no_auto_sel: got %0d want 0", vid.src_sel); end
  endtask
  task automatic test_autocycle();
    int bad, sbad;
    run_cycles(FL, S0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL auto_frame2: %0d bad pixels, want 0", bad); end
    run_cycles(FL, S0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL auto_frame3: %0d bad pixels, want 0", bad); end
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL auto_black: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd1) begin mismatched++; $display("FAIL auto_sel: got %0d want 1", vid.src_sel); end
    compared++;
    if (vid.video_en !== 1'b0) begin mismatched++; $display("FAIL auto_switch_en: got %b want 0", vid.video_en); end
    run_cycles(FL, S1, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL auto_src1: %0d bad pixels, want 0", bad); end
  endtask
  task automatic test_key_switch();
    int bad, sbad;
    repeat (20) step();
    press(20);
    align();
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL key_black: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd1) begin mismatched++; $display("FAIL key_sel: got %0d want 1", vid.src_sel); end
    compared++;
    if (vid.video_en !== 1'b0) begin mismatched++; $display("FAIL key_switch_en: got %b want 0", vid.video_en); end
    run_cycles(FL, S1, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL key_src1: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.video_en !== 1'b1) begin mismatched++; $display("FAIL key_run_en: got %b want 1", vid.video_en); end
  endtask
  task automatic test_wrap();
    int bad, sbad;
    for (int k = 2; k < 5; k++) begin
      repeat (10) step();
      press(20);
      align();
      run_cycles(FL, 24'h0, bad, sbad);
      compared++;
      if (bad !== 0) begin mismatched++; $display("FAIL wrap_black_%0d: %0d bad pixels, want 0", k % 4, bad); end
      compared++;
      if (vid.src_sel !== 2'(k % 4)) begin mismatched++; $display("FAIL wrap_sel: got %0d want %0d", vid.src_sel, k % 4); end
      run_cycles(FL, srcs[k % 4], bad, sbad);
      compared++;
      if (bad !== 0) begin mismatched++; $display("FAIL wrap_src_%0d: %0d bad pixels, want 0", k % 4, bad); end
    end
  endtask
  task automatic test_glitch();
    int bad, sbad;
    repeat (8) step();
    repeat (3) begin
      vid.key_n = 1'b0;
      repeat (5) step();
      vid.key_n = 1'b1;
      repeat (10) step();
    end
    align();
    run_cycles(FL, S0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL glitch_pixels: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd0) begin mismatched++; $display("FAIL glitch_sel: got %0d want 0", vid.src_sel); end
  endtask
  task automatic test_double_press();
    int bad, sbad;
    repeat (4) step();
    press(12);
    press(12);
    align();
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL double_black: %0d bad pixels, want 0", bad); end
    run_cycles(FL, S1, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL double_src1: %0d bad pixels, want 0", bad); end
    run_cycles(FL, S1, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL double_no_second: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd1) begin mismatched++; $display("FAIL double_sel: got %0d want 1", vid.src_sel); end
  endtask
  task automatic test_lock_drop();
    int bad, sbad;
    repeat (20) step();
    vid.pll_lock = 1'b0;
    repeat (4) step();
    compared++;
    if (vid.rgb_out !== 24'h0) begin mismatched++; $display("FAIL drop_rgb: got %h want 000000", vid.rgb_out); end
    compared++;
    if (vid.video_en !== 1'b0) begin mismatched++; $display("FAIL drop_en: got %b want 0", vid.video_en); end
    run_cycles(FL - 24, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL drop_black: %0d bad pixels, want 0", bad); end
    compared++;
    if (sbad !== 0) begin mismatched++; $display("FAIL drop_syncs: %0d bad sync samples, want 0", sbad); end
    vid.pll_lock = 1'b1;
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL relock_black1: %0d bad pixels, want 0", bad); end
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL relock_black2: %0d bad pixels, want 0", bad); end
    run_cycles(FL, S1, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL relock_src1: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd1) begin mismatched++; $display("FAIL relock_sel: got %0d want 1", vid.src_sel); end
  endtask
  task automatic test_press_on_fe();
    int bad, sbad;
    repeat (54) step();
    bad = 0;
    vid.key_n = 1'b0;
    // the debounced press pulse lands on the edge that samples vsync_in rising at position 0
    for (int i = 0; i < 74; i++) begin
      step();
      if (vid.rgb_out !== (a_d ? S1 : 24'h0)) bad++;
      if (i == 11) vid.key_n = 1'b1;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL fe_press_same_frame: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd1) begin mismatched++; $display("FAIL fe_press_sel_early: got %0d want 1", vid.src_sel); end
    run_cycles(FL, 24'h0, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL fe_press_black: %0d bad pixels, want 0", bad); end
    compared++;
    if (vid.src_sel !== 2'd2) begin mismatched++; $display("FAIL fe_press_sel: got %0d want 2", vid.src_sel); end
    run_cycles(FL, S2, bad, sbad);
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL fe_press_src2: %0d bad pixels, want 0", bad); end
  endtask
  task automatic test_async_reset(input logic [23:0] exp);
    repeat (30) step();
    compared++;
    if (vid.rgb_out !== exp) begin mismatched++; $display("FAIL pre_reset_rgb: got %h want %h", vid.rgb_out, exp); end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({vid.rgb_out, vid.hsync_out, vid.vsync_out, vid.active_out, vid.src_sel, vid.video_en} !== 30'h0) begin
      mismatched++;
      $display("FAIL async_reset: got %h want 0", {vid.rgb_out, vid.hsync_out, vid.vsync_out, vid.active_out, vid.src_sel, vid.video_en});
    end
  endtask
  initial begin
    srcs[0] = S0;
    srcs[1] = S1;
    srcs[2] = S2;
    srcs[3] = S3;
    vid.pll_lock = 1'b0;
    vid.key_n = 1'b1;
    vid.src0_rgb = S0;
    vid.src1_rgb = S1;
    vid.src2_rgb = S2;
    vid.src3_rgb = S3;
    drive_timing();
    test_reset();
    test_lock_mute();
`ifdef HDMI_SEQ_AUTOCYCLE_EN
    test_autocycle();
    test_async_reset(S1);
`else
    test_no_autocycle();
    test_key_switch();
    test_wrap();
    test_glitch();
    test_double_press();
    test_lock_drop();
    test_press_on_fe();
    test_async_reset(S2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
